// File: rtl/vga_capture.sv
// VGA receive-side capture: recovers pixel coordinates, measures mode timing and locks to H_ACTIVE x V_ACTIVE.
// Optional per-frame CRC-16-CCITT of emitted pixels when VGA_CAPTURE_CRC_EN is defined.
module vga_capture #(
  parameter int   H_ACTIVE = 800,
  parameter int   V_ACTIVE = 600,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic [10:0] h_total,
  output logic [10:0] h_active,
  output logic [9:0]  v_total,
  output logic [9:0]  v_active,
  output logic        locked,
  output logic        timing_err,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  function automatic logic [10:0] inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  state_t      state_q, state_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_a_q, hs_a_d, vs_a_q, vs_a_d, blank_q, blank_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, blank_prev_q, blank_prev_d;
  logic [10:0] hcnt_q, hcnt_d, acnt_q, acnt_d, prev_ht_q, prev_ht_d;
  logic [9:0]  vcnt_q, vcnt_d, vact_q, vact_d, prev_vt_q, prev_vt_d;
  logic        line_act_q, line_act_d, frame_bad_q, frame_bad_d, prev_ok_q, prev_ok_d;
  logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic        locked_q, locked_d, timing_err_q, timing_err_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [23:0] pix_rgb_q, pix_rgb_d;
  logic [10:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [9:0]  v_total_q, v_total_d, v_active_q, v_active_d;

  logic        hs_edge, vs_edge, blank_rise, blank_fall;
  logic        line_bad, line_act_now, frame_bad_now, lock_ok;
  logic [10:0] cur_x;
  logic [9:0]  vact_now;

  assign hs_edge    = hs_a_q & ~hs_prev_q;
  assign vs_edge    = vs_a_q & ~vs_prev_q;
  assign blank_rise = blank_q & ~blank_prev_q;
  assign blank_fall = ~blank_q & blank_prev_q;

  // Input sampling, counters, measurements, lock FSM and output stage next-state
  always_comb begin
    hs_a_d       = (VGA_HS == HS_POL);
    vs_a_d       = (VGA_VS == VS_POL);
    blank_d      = VGA_BLANK_N;
    rgb_d        = {VGA_R, VGA_G, VGA_B};
    hs_prev_d    = hs_a_q;
    vs_prev_d    = vs_a_q;
    blank_prev_d = blank_q;

    hcnt_d     = hs_edge ? 11'd0 : inc11(hcnt_q);
    h_total_d  = hs_edge ? inc11(hcnt_q) : h_total_q;
    acnt_d     = blank_q ? (blank_rise ? 11'd1 : inc11(acnt_q)) : acnt_q;
    cur_x      = blank_rise ? 11'd0 : acnt_q;
    h_active_d = blank_fall ? acnt_q : h_active_q;

    // A line ending on the VS edge still belongs to the frame being closed
    line_bad      = blank_fall && (acnt_q != 11'(H_ACTIVE));
    line_act_now  = line_act_q || blank_fall;
    frame_bad_now = frame_bad_q || line_bad;
    vact_now      = blank_fall ? inc10(vact_q) : vact_q;
    vcnt_d        = vs_edge ? 10'd0 : (hs_edge ? inc10(vcnt_q) : vcnt_q);
    vact_d        = vs_edge ? 10'd0 : vact_now;
    v_total_d     = vs_edge ? vcnt_q : v_total_q;
    v_active_d    = vs_edge ? vact_now : v_active_q;
    line_act_d    = vs_edge ? 1'b0 : line_act_now;
    frame_bad_d   = vs_edge ? 1'b0 : frame_bad_now;

    lock_ok = prev_ok_q && line_act_now && !frame_bad_now &&
              (h_active_d == 11'(H_ACTIVE)) && (v_active_d == 10'(V_ACTIVE)) &&
              (h_total_d == prev_ht_q) && (v_total_d == prev_vt_q);

    // A frame that contained a bad line, or the first frame after reset, cannot vouch for the next
    prev_ht_d = vs_edge ? h_total_d : prev_ht_q;
    prev_vt_d = vs_edge ? v_total_d : prev_vt_q;
    prev_ok_d = vs_edge ? ((state_q != SEARCH) && !frame_bad_now) : prev_ok_q;

    state_d = state_q;
    case (state_q)
      SEARCH:  state_d = vs_edge ? MEASURE : SEARCH;
      MEASURE: state_d = (vs_edge && lock_ok) ? LOCKED : MEASURE;
      LOCKED:  state_d = ((vs_edge && !lock_ok) || line_bad) ? MEASURE : LOCKED;
      default: state_d = SEARCH;
    endcase

    locked_d      = (state_d == LOCKED);
    timing_err_d  = (state_q == LOCKED) && (state_d != LOCKED);
    pix_valid_d   = blank_q && locked_d;
    pix_x_d       = (cur_x > 11'd1023) ? 10'd1023 : cur_x[9:0];
    pix_y_d       = vact_q;
    pix_rgb_d     = rgb_q;
    frame_start_d = vs_edge;
  end

  // State register for every stage of the capture path
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH;
      rgb_q <= 24'd0;  hs_a_q <= 1'b0;  vs_a_q <= 1'b0;  blank_q <= 1'b0;
      hs_prev_q <= 1'b0;  vs_prev_q <= 1'b0;  blank_prev_q <= 1'b0;
      hcnt_q <= 11'd0;  acnt_q <= 11'd0;  prev_ht_q <= 11'd0;
      vcnt_q <= 10'd0;  vact_q <= 10'd0;  prev_vt_q <= 10'd0;
      line_act_q <= 1'b0;  frame_bad_q <= 1'b0;  prev_ok_q <= 1'b0;
      pix_valid_q <= 1'b0;  frame_start_q <= 1'b0;  locked_q <= 1'b0;  timing_err_q <= 1'b0;
      pix_x_q <= 10'd0;  pix_y_q <= 10'd0;  pix_rgb_q <= 24'd0;
      h_total_q <= 11'd0;  h_active_q <= 11'd0;  v_total_q <= 10'd0;  v_active_q <= 10'd0;
    end else begin
      state_q <= state_d;
      rgb_q <= rgb_d;  hs_a_q <= hs_a_d;  vs_a_q <= vs_a_d;  blank_q <= blank_d;
      hs_prev_q <= hs_prev_d;  vs_prev_q <= vs_prev_d;  blank_prev_q <= blank_prev_d;
      hcnt_q <= hcnt_d;  acnt_q <= acnt_d;  prev_ht_q <= prev_ht_d;
      vcnt_q <= vcnt_d;  vact_q <= vact_d;  prev_vt_q <= prev_vt_d;
      line_act_q <= line_act_d;  frame_bad_q <= frame_bad_d;  prev_ok_q <= prev_ok_d;
      pix_valid_q <= pix_valid_d;  frame_start_q <= frame_start_d;
      locked_q <= locked_d;  timing_err_q <= timing_err_d;
      pix_x_q <= pix_x_d;  pix_y_q <= pix_y_d;  pix_rgb_q <= pix_rgb_d;
      h_total_q <= h_total_d;  h_active_q <= h_active_d;
      v_total_q <= v_total_d;  v_active_q <= v_active_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;

`ifdef VGA_CAPTURE_CRC_EN
  // CRC-16-CCITT, MSB first, all 24 bits of one pixel per clock
  function automatic logic [15:0] crc16_24(input logic [15:0] crc, input logic [23:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      c = (c[15] ^ data[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  logic [15:0] crc_acc_q, crc_acc_d, frame_crc_q, frame_crc_d, crc_upd;

  // Accumulate emitted pixels; close and restart the frame on the VS edge
  always_comb begin
    crc_upd     = pix_valid_q ? crc16_24(crc_acc_q, pix_rgb_q) : crc_acc_q;
    crc_acc_d   = vs_edge ? 16'hFFFF : crc_upd;
    frame_crc_d = vs_edge ? crc_upd : frame_crc_q;
  end

  // CRC accumulator and latched result
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      crc_acc_q   <= 16'hFFFF;
      frame_crc_q <= 16'h0000;
    end else begin
      crc_acc_q   <= crc_acc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced 16x8 mode (24x14 totals): lock, pixel stream, bad line, mid-frame reset, inverted syncs.
module tb_vga_capture;
  localparam int HA = 16, VA = 8, HT = 24, VT = 14;
  localparam int HS_W = 3, HA0 = 5, VSP = 5, VA0 = 3, NF = 12;
  localparam logic [0:11] LOCK_PLAN = 12'b0011_1001_0011;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
    int          cyc;
  } pix_t;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [7:0]  r, g, b;
  logic        hs_a, vs_a, blank, hs_n, vs_n;
  logic        pix_valid, frame_start, locked, timing_err;
  logic [9:0]  pix_x, pix_y, v_total, v_active;
  logic [23:0] pix_rgb;
  logic [10:0] h_total, h_active;
  logic [15:0] frame_crc;
  logic        p_pix_valid, p_frame_start, p_locked, p_timing_err;
  logic [9:0]  p_pix_x, p_pix_y, p_v_total, p_v_active;
  logic [23:0] p_pix_rgb;
  logic [10:0] p_h_total, p_h_active;
  logic [15:0] p_frame_crc;

  pix_t        sb_q[$];
  int          n_cmp, n_bad, cyc, te_cnt, te_exp_cyc, fs_cnt, rst_left;
  bit          exp_lock, rst_chk;
  logic [15:0] crc_m;
  logic [0:11] plan;

  assign hs_n = ~hs_a;
  assign vs_n = ~vs_a;

  always #5 vga_clk = ~vga_clk;

  vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA)) u_dut (
    .vga_clk(vga_clk), .reset(reset), .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .VGA_HS(hs_n), .VGA_VS(vs_n), .VGA_BLANK_N(blank),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active), .locked(locked),
    .timing_err(timing_err), .frame_crc(frame_crc)
  );

  vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .HS_POL(1'b1), .VS_POL(1'b1)) u_dut_p (
    .vga_clk(vga_clk), .reset(reset), .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(blank),
    .pix_valid(p_pix_valid), .pix_x(p_pix_x), .pix_y(p_pix_y), .pix_rgb(p_pix_rgb),
    .frame_start(p_frame_start), .h_total(p_h_total), .h_active(p_h_active),
    .v_total(p_v_total), .v_active(p_v_active), .locked(p_locked),
    .timing_err(p_timing_err), .frame_crc(p_frame_crc)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    return x;
  endfunction

  task automatic monitor();
    pix_t it;
    if (rst_chk) begin
      rst_chk = 1'b0;
      chk("rst_outs", {pix_valid, pix_x, pix_y, pix_rgb, frame_start, h_total, h_active,
                       v_total, v_active, locked, timing_err, frame_crc}, 128'd0);
    end
    if (timing_err) begin
      te_cnt++;
      chk("terr_cycle", cyc, te_exp_cyc);
      chk("terr_locked", locked, 1'b0);
    end
    if (frame_start) begin
      fs_cnt++;
`ifdef VGA_CAPTURE_CRC_EN
      chk("frame_crc", frame_crc, crc_m);
      crc_m = 16'hFFFF;
`else
      chk("frame_crc_off", frame_crc, 16'h0000);
`endif
    end
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      chk("pix_missing", 1'b0, 1'b1);
      it = sb_q.pop_front();
    end
    if (pix_valid) begin
      if (sb_q.size() == 0) begin
        chk("pix_extra", 1'b1, 1'b0);
      end else begin
        it = sb_q.pop_front();
        chk("pix_x", pix_x, it.x);
        chk("pix_y", pix_y, it.y);
        chk("pix_rgb", pix_rgb, it.rgb);
        chk("pix_latency", cyc, it.cyc);
        crc_m = crc_byte(crc_byte(crc_byte(crc_m, it.rgb[23:16]), it.rgb[15:8]), it.rgb[7:0]);
      end
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic checkpoint(input int f);
    chk($sformatf("locked_f%0d", f), locked, plan[f]);
    chk($sformatf("locked_pol_f%0d", f), p_locked, plan[f]);
    if (plan[f]) begin
      chk("h_total", h_total, HT);
      chk("h_active", h_active, HA);
      chk("v_total", v_total, VT);
      chk("v_active", v_active, VA);
      chk("pol_meas", {p_h_total, p_h_active, p_v_total, p_v_active},
          {11'(HT), 11'(HA), 10'(VT), 10'(VA)});
    end
  endtask

  initial begin
    int row, w;
    bit act_row;
    n_cmp = 0; n_bad = 0; cyc = 0; te_cnt = 0; te_exp_cyc = -1; fs_cnt = 0;
    rst_left = 0; rst_chk = 1'b0; exp_lock = 1'b0; crc_m = 16'hFFFF; plan = LOCK_PLAN;
    reset = 1'b1; hs_a = 1'b0; vs_a = 1'b0; blank = 1'b0; r = 8'h00; g = 8'h00; b = 8'h00;
    repeat (3) step();
    chk("reset_outs", {pix_valid, pix_x, pix_y, pix_rgb, frame_start, h_total, h_active,
                       v_total, v_active, locked, timing_err, frame_crc}, 128'd0);
    reset = 1'b0;

    for (int f = 0; f < NF; f++) begin
      for (int l = 0; l < VT; l++) begin
        for (int p = 0; p < HT; p++) begin
          step();
          if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) reset = 1'b0;
          end
          hs_a    = (p < HS_W);
          vs_a    = (l == 0 && p >= VSP) || (l == 1) || (l == 2 && p < VSP);
          act_row = (l >= VA0) && (l < VA0 + VA);
          row     = l - VA0;
          w       = (f == 4 && row == 2) ? HA - 1 : HA;
          blank   = act_row && (p >= HA0) && (p < HA0 + w);
          if (l == 0 && p == VSP) exp_lock = plan[f];
          if (f == 4 && row == 2 && p == HA0 + w) begin
            te_exp_cyc = cyc + 2;
            exp_lock   = 1'b0;
          end
          if (f == 7 && row == 3 && p == HA0 + 5) begin
            reset = 1'b1; rst_left = 3; rst_chk = 1'b1; exp_lock = 1'b0;
            sb_q.delete();
            crc_m = 16'hFFFF;
          end
          r = blank ? 8'(p - HA0) : 8'h00;
          g = blank ? 8'(row) : 8'h00;
          b = blank ? 8'h5A : 8'h00;
          if (blank && exp_lock) sb_q.push_back('{p - HA0, row, {r, g, b}, cyc + 2});
          if (l == 1 && p == 0) checkpoint(f);
        end
      end
    end

    hs_a = 1'b0; vs_a = 1'b0; blank = 1'b0; r = 8'h00; g = 8'h00; b = 8'h00;
    repeat (6) step();
    chk("sb_empty", sb_q.size(), 0);
    chk("terr_count", te_cnt, 1);
    chk("fs_count", fs_cnt, NF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
